// File: rtl/serdes_seq_pkg.sv
// rtl/serdes_seq_pkg.sv - shared state encoding and sizing helpers for the SerDes bring-up sequencer
package serdes_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_PGOOD = 3'd1,
        ST_SETTLE     = 3'd2,
        ST_RESET      = 3'd3,
        ST_WAIT_DONE  = 3'd4,
        ST_RUN        = 3'd5,
        ST_FAIL       = 3'd6
    } seq_state_t;

    localparam int RETRY_CNT_W = 8;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serdes_bringup_seq_if.sv
// rtl/serdes_bringup_seq_if.sv - transceiver-wizard control/status bundle between sequencer and quad
interface serdes_bringup_seq_if #(
    parameter int LANES = 4
);
    logic [LANES-1:0] pwrgood;
    logic [LANES-1:0] tx_pmaresetdone;
    logic [LANES-1:0] rx_pmaresetdone;
    logic [LANES-1:0] link_up;
    logic             reset_tx_done;
    logic             reset_rx_done;
    logic             gt_reset_all;
    logic             userclk_tx_active;
    logic             userclk_rx_active;
    logic [LANES-1:0] lane_rx_reset;

    modport master (
        input  pwrgood, tx_pmaresetdone, rx_pmaresetdone, link_up,
        input  reset_tx_done, reset_rx_done,
        output gt_reset_all, userclk_tx_active, userclk_rx_active, lane_rx_reset
    );

    modport slave (
        output pwrgood, tx_pmaresetdone, rx_pmaresetdone, link_up,
        output reset_tx_done, reset_rx_done,
        input  gt_reset_all, userclk_tx_active, userclk_rx_active, lane_rx_reset
    );
endinterface

// File: rtl/serdes_lane_watchdog.sv
// rtl/serdes_lane_watchdog.sv - per-lane link-down watchdog issuing a fixed-width RX datapath reset
module serdes_lane_watchdog
    import serdes_seq_pkg::*;
#(
    parameter int LINK_TIMEOUT      = 1250000,
    parameter int LANE_RESET_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic link_up,
    output logic lane_rx_reset
);

    localparam int TW = cnt_width(LINK_TIMEOUT);
    localparam int PW = cnt_width(LANE_RESET_CYCLES);

    logic [TW-1:0] r_down_cnt;
    logic [PW-1:0] r_pulse_cnt;
    logic          r_pulse;

    // Link state is ignored while the pulse runs; the count restarts afterwards.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_down_cnt  <= '0;
            r_pulse_cnt <= '0;
            r_pulse     <= 1'b0;
        end else if (r_pulse) begin
            if (r_pulse_cnt == PW'(LANE_RESET_CYCLES - 1)) begin
                r_pulse     <= 1'b0;
                r_pulse_cnt <= '0;
                r_down_cnt  <= '0;
            end else begin
                r_pulse_cnt <= r_pulse_cnt + 1'b1;
            end
        end else if (link_up) begin
            r_down_cnt <= '0;
        end else if (r_down_cnt == TW'(LINK_TIMEOUT - 1)) begin
            r_pulse     <= 1'b1;
            r_pulse_cnt <= '0;
            r_down_cnt  <= '0;
        end else begin
            r_down_cnt <= r_down_cnt + 1'b1;
        end
    end

    assign lane_rx_reset = r_pulse;

endmodule

// File: rtl/serdes_bringup_seq.sv
// rtl/serdes_bringup_seq.sv - power-good, reset-retry and link-recovery sequencer for one transceiver quad
module serdes_bringup_seq
    import serdes_seq_pkg::*;
#(
    parameter int LANES             = 4,
    parameter int SETTLE_CYCLES     = 65535,
    parameter int RESET_CYCLES      = 16,
    parameter int DONE_TIMEOUT      = 1000000,
    parameter int MAX_RETRIES       = 3,
    parameter int LINK_TIMEOUT      = 1250000,
    parameter int LANE_RESET_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    serdes_bringup_seq_if.master   gt,
    output logic                   ready,
    output logic                   failed,
    output logic [2:0]             state,
    output logic [RETRY_CNT_W-1:0] total_retries
);

    localparam int CNT_MAX_A = (SETTLE_CYCLES > RESET_CYCLES) ? SETTLE_CYCLES : RESET_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > DONE_TIMEOUT) ? CNT_MAX_A : DONE_TIMEOUT;
    localparam int CW        = cnt_width(CNT_MAX);
    localparam int AW        = cnt_width(MAX_RETRIES + 1);
    localparam int SW        = 4 * LANES + 2;

    logic [SW-1:0]          w_async;
    logic [SW-1:0]          r_sync1;
    logic [SW-1:0]          r_sync2;
    logic                   w_done;
    logic                   w_pg_all;
    logic [LANES-1:0]       w_txp;
    logic [LANES-1:0]       w_rxp;
    logic [LANES-1:0]       w_link;
    logic [LANES-1:0]       w_lane_rst;
    logic                   w_wd_enable;

    seq_state_t             r_state;
    seq_state_t             w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;
    logic [AW-1:0]          r_attempt;
    logic [AW-1:0]          w_attempt_nxt;
    logic [RETRY_CNT_W-1:0] r_retries;
    logic [RETRY_CNT_W-1:0] w_retries_nxt;

    logic                   r_gt_reset;
    logic                   r_utx;
    logic                   r_urx;
    logic                   r_ready;
    logic                   r_failed;

    assign w_async = {gt.link_up, gt.rx_pmaresetdone, gt.tx_pmaresetdone, gt.pwrgood,
                      gt.reset_rx_done, gt.reset_tx_done};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_async;
            r_sync2 <= r_sync1;
        end
    end

    assign w_done   = r_sync2[0] & r_sync2[1];
    assign w_pg_all = &r_sync2[2 +: LANES];
    assign w_txp    = r_sync2[2 + LANES +: LANES];
    assign w_rxp    = r_sync2[2 + 2 * LANES +: LANES];
    assign w_link   = r_sync2[2 + 3 * LANES +: LANES];

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_attempt_nxt = r_attempt;
        w_retries_nxt = r_retries;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_WAIT_PGOOD;
            ST_WAIT_PGOOD: begin
                if (w_pg_all) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SETTLE: begin
                if (!w_pg_all) begin
                    w_state_nxt = ST_WAIT_PGOOD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
                    w_state_nxt = ST_RESET;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_RESET: begin
                if (!w_pg_all) begin
                    w_state_nxt = ST_WAIT_PGOOD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CW'(RESET_CYCLES - 1)) begin
                    w_state_nxt = ST_WAIT_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                // Power-good loss outranks done flags, which outrank the timeout.
                if (!w_pg_all) begin
                    w_state_nxt = ST_WAIT_PGOOD;
                    w_cnt_nxt   = '0;
                end else if (w_done) begin
                    w_state_nxt   = ST_RUN;
                    w_cnt_nxt     = '0;
                    w_attempt_nxt = '0;
                end else if (r_cnt == CW'(DONE_TIMEOUT - 1)) begin
                    w_cnt_nxt = '0;
                    if (r_retries != '1) begin
                        w_retries_nxt = r_retries + 1'b1;
                    end
                    if (r_attempt == AW'(MAX_RETRIES - 1)) begin
                        w_state_nxt = ST_FAIL;
                    end else begin
                        w_state_nxt   = ST_RESET;
                        w_attempt_nxt = r_attempt + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (!w_pg_all) begin
                    w_state_nxt = ST_WAIT_PGOOD;
                    w_cnt_nxt   = '0;
                end
            end
            ST_FAIL: w_state_nxt = ST_FAIL;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs follow the next state so they change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_attempt  <= '0;
            r_retries  <= '0;
            r_gt_reset <= 1'b0;
            r_utx      <= 1'b0;
            r_urx      <= 1'b0;
            r_ready    <= 1'b0;
            r_failed   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_attempt  <= w_attempt_nxt;
            r_retries  <= w_retries_nxt;
            r_gt_reset <= (w_state_nxt == ST_RESET);
            r_utx      <= (w_state_nxt == ST_RUN) || ((w_state_nxt == ST_WAIT_DONE) && (&w_txp));
            r_urx      <= (w_state_nxt == ST_RUN) || ((w_state_nxt == ST_WAIT_DONE) && (&w_rxp));
            r_ready    <= (w_state_nxt == ST_RUN);
            r_failed   <= (w_state_nxt == ST_FAIL);
        end
    end

    // Enabling on the next state lets a pulse in progress drop on the edge RUN is left.
    assign w_wd_enable = (w_state_nxt == ST_RUN);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        serdes_lane_watchdog #(
            .LINK_TIMEOUT      (LINK_TIMEOUT),
            .LANE_RESET_CYCLES (LANE_RESET_CYCLES)
        ) u_wd (
            .clk           (clk),
            .rst           (rst),
            .enable        (w_wd_enable),
            .link_up       (w_link[g]),
            .lane_rx_reset (w_lane_rst[g])
        );
    end

    assign gt.gt_reset_all      = r_gt_reset;
    assign gt.userclk_tx_active = r_utx;
    assign gt.userclk_rx_active = r_urx;
    assign gt.lane_rx_reset     = w_lane_rst;
    assign ready                = r_ready;
    assign failed               = r_failed;
    assign state                = r_state;
    assign total_retries        = r_retries;

endmodule
